// File: rtl/id_dispatch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// id_dispatch_buffer_pkg
//   Shared constants for the decoded-instruction dispatch buffer: default
//   geometry, plus the field layout of the per-lane decoded payload. The
//   decoder bank and the dispatch stage both import this package so they agree
//   on where every field sits inside a PAYLOAD_W-wide lane.
// -----------------------------------------------------------------------------
package id_dispatch_buffer_pkg;

    // Default geometry
    localparam int IDB_LANES_DEF     = 2;
    localparam int IDB_DEPTH_DEF     = 4;
    localparam int IDB_PAYLOAD_W_DEF = 64;
    localparam int IDB_RS_ENT_W_DEF  = 3;

    // Payload field offsets / widths (LSB first inside one lane)
    localparam int IDB_IMM_TYPE_OFS   = 0;
    localparam int IDB_IMM_TYPE_W     = 3;
    localparam int IDB_REG_SEL_W      = 5;
    localparam int IDB_RS1_OFS        = 3;
    localparam int IDB_RS2_OFS        = 8;
    localparam int IDB_RD_OFS         = 13;
    localparam int IDB_SRC_A_SEL_OFS  = 18;
    localparam int IDB_SRC_A_SEL_W    = 2;
    localparam int IDB_SRC_B_SEL_OFS  = 20;
    localparam int IDB_SRC_B_SEL_W    = 2;
    localparam int IDB_ALU_OP_OFS     = 22;
    localparam int IDB_ALU_OP_W       = 5;
    localparam int IDB_MEM_TYPE_OFS   = 27;
    localparam int IDB_MEM_TYPE_W     = 4;
    localparam int IDB_MD_OP_OFS      = 31;
    localparam int IDB_MD_OP_W        = 3;
    localparam int IDB_MD_OUT_SEL_OFS = 34;
    localparam int IDB_MD_OUT_SEL_W   = 2;
    localparam int IDB_FIELDS_W       = 36;

    // Packed view of the used low bits of a lane payload (MSB field first)
    typedef struct packed {
        logic [IDB_MD_OUT_SEL_W-1:0] md_out_sel;
        logic [IDB_MD_OP_W-1:0]      md_op;
        logic [IDB_MEM_TYPE_W-1:0]   mem_type;
        logic [IDB_ALU_OP_W-1:0]     alu_op;
        logic [IDB_SRC_B_SEL_W-1:0]  src_b_sel;
        logic [IDB_SRC_A_SEL_W-1:0]  src_a_sel;
        logic [IDB_REG_SEL_W-1:0]    rd;
        logic [IDB_REG_SEL_W-1:0]    rs2;
        logic [IDB_REG_SEL_W-1:0]    rs1;
        logic [IDB_IMM_TYPE_W-1:0]   imm_type;
    } idb_fields_t;

    // Extract the decoded fields from the low bits of one lane payload
    function automatic idb_fields_t idb_unpack(input logic [IDB_FIELDS_W-1:0] lane);
        return idb_fields_t'(lane);
    endfunction

endpackage

// File: rtl/id_dispatch_buffer_ptr.sv
// -----------------------------------------------------------------------------
// id_buf_ptr
//   Read/write pointer pair for a power-of-two circular queue. Pointers carry
//   one extra wrap bit so full and empty are distinguishable without a
//   separate counter register. kill_i returns both pointers to zero and
//   overrides any concurrent push/pop.
// Ports
//   clk_i, reset_i    clock, asynchronous active-high reset
//   kill_i            flush: pointers -> 0 at the next edge
//   push_i, pop_i     advance write / read pointer (caller guarantees legality)
//   wr_idx_o/rd_idx_o storage index of tail / head
//   count_o           occupied entries (0..DEPTH)
//   full_o, empty_o   queue status
// -----------------------------------------------------------------------------
module id_buf_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     kill_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH)-1:0] wr_idx_o,
    output logic [$clog2(DEPTH)-1:0] rd_idx_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;

    always_comb begin
        wr_d = wr_q + {{AW{1'b0}}, push_i};
        rd_d = rd_q + {{AW{1'b0}}, pop_i};
        if (kill_i) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    assign wr_idx_o = wr_q[AW-1:0];
    assign rd_idx_o = rd_q[AW-1:0];
    // Modular difference of the extended pointers is the occupancy
    assign count_o  = wr_q - rd_q;
    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/id_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// id_dispatch_buffer
//   LANES-wide decoded-instruction FIFO between the decoder bank and dispatch.
//   Decouples decode from dispatch stalls without dropping bundles. Bundles
//   whose lanes are all invalid complete the handshake but are not stored.
//   Invalid lanes are stored with their RS select forced to zero.
//   Optional build macro ID_DISPATCH_BYPASS_EN: when the buffer is empty and
//   dispatch is ready, an incoming bundle is passed straight through to out_*
//   in the same cycle without being written. Undefined: fixed one-cycle
//   latency and no combinational in->out path.
// Ports
//   clk_i, reset_i   clock, asynchronous active-high reset
//   kill_i           flush all entries
//   in_valid_i / in_ready_o               decoder-side handshake
//   in_inv_i, in_rs_ent_i, in_payload_i   bundle (lane 0 in LSBs)
//   out_valid_o / out_ready_i             dispatch-side handshake
//   out_lane_vld_o, out_rs_ent_o, out_payload_o   head bundle, zero when idle
//   count_o          occupied entries
// -----------------------------------------------------------------------------
module id_dispatch_buffer
    import id_dispatch_buffer_pkg::*;
#(
    parameter int LANES     = IDB_LANES_DEF,
    parameter int DEPTH     = IDB_DEPTH_DEF,
    parameter int PAYLOAD_W = IDB_PAYLOAD_W_DEF,
    parameter int RS_ENT_W  = IDB_RS_ENT_W_DEF
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         kill_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [LANES-1:0]             in_inv_i,
    input  logic [LANES*RS_ENT_W-1:0]    in_rs_ent_i,
    input  logic [LANES*PAYLOAD_W-1:0]   in_payload_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [LANES-1:0]             out_lane_vld_o,
    output logic [LANES*RS_ENT_W-1:0]    out_rs_ent_o,
    output logic [LANES*PAYLOAD_W-1:0]   out_payload_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int AW = $clog2(DEPTH);

    logic          full, empty;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          any_lane;
    logic          bypass;
    logic          push, pop;

    logic [LANES*RS_ENT_W-1:0] in_rs_masked;

    logic [LANES-1:0]           vld_q [DEPTH];
    logic [LANES*RS_ENT_W-1:0]  rs_q  [DEPTH];
    logic [LANES*PAYLOAD_W-1:0] pl_q  [DEPTH];

    assign any_lane   = |(~in_inv_i);
    assign in_ready_o = ~full;

`ifdef ID_DISPATCH_BYPASS_EN
    // Empty and dispatch ready: the incoming bundle goes straight out
    assign bypass = empty & out_ready_i & ~kill_i;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed bundle is consumed without touching storage or pointers
    assign push = in_valid_i & ~full & ~kill_i & any_lane & ~bypass;
    assign pop  = ~empty & out_ready_i & ~kill_i;

    always_comb begin
        in_rs_masked = in_rs_ent_i;
        for (int i = 0; i < LANES; i++) begin
            if (in_inv_i[i]) begin
                in_rs_masked[i*RS_ENT_W +: RS_ENT_W] = '0;
            end
        end
    end

    id_buf_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .kill_i   (kill_i),
        .push_i   (push),
        .pop_i    (pop),
        .wr_idx_o (wr_idx),
        .rd_idx_o (rd_idx),
        .count_o  (count_o),
        .full_o   (full),
        .empty_o  (empty)
    );

    // Storage is data-only: stale contents are harmless because every
    // output is gated by the pointer state.
    always_ff @(posedge clk_i) begin
        if (push) begin
            vld_q[wr_idx] <= ~in_inv_i;
            rs_q[wr_idx]  <= in_rs_masked;
            pl_q[wr_idx]  <= in_payload_i;
        end
    end

    always_comb begin
        out_valid_o    = 1'b0;
        out_lane_vld_o = '0;
        out_rs_ent_o   = '0;
        out_payload_o  = '0;
        if (!empty) begin
            out_valid_o    = 1'b1;
            out_lane_vld_o = vld_q[rd_idx];
            out_rs_ent_o   = rs_q[rd_idx];
            out_payload_o  = pl_q[rd_idx];
        end else if (bypass && in_valid_i && any_lane) begin
            out_valid_o    = 1'b1;
            out_lane_vld_o = ~in_inv_i;
            out_rs_ent_o   = in_rs_masked;
            out_payload_o  = in_payload_i;
        end
    end

endmodule

// File: tb/tb_id_dispatch_buffer.sv
module tb_id_dispatch_buffer;
    localparam int LANES = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 64;
    localparam int RW    = 3;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             kill_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [LANES-1:0] in_inv_i;
    logic [LANES*RW-1:0] in_rs_ent_i;
    logic [LANES*PW-1:0] in_payload_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [LANES-1:0] out_lane_vld_o;
    logic [LANES*RW-1:0] out_rs_ent_o;
    logic [LANES*PW-1:0] out_payload_o;
    logic [$clog2(DEPTH):0] count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_dispatch_buffer #(
        .LANES(LANES), .DEPTH(DEPTH), .PAYLOAD_W(PW), .RS_ENT_W(RW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .kill_i         (kill_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_inv_i       (in_inv_i),
        .in_rs_ent_i    (in_rs_ent_i),
        .in_payload_i   (in_payload_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_lane_vld_o (out_lane_vld_o),
        .out_rs_ent_o   (out_rs_ent_o),
        .out_payload_o  (out_payload_o),
        .count_o        (count_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] inv, input logic [2:0] rs,
                         input logic [63:0] p0, input logic [63:0] p1);
        in_valid_i   = v;
        in_inv_i     = inv;
        in_rs_ent_i  = {rs, rs};
        in_payload_i = {p1, p0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i     = 1'b1;
        kill_i      = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        tick();
        tick();
        check("rst_count",   count_o, 0);
        check("rst_valid",   out_valid_o, 0);
        check("rst_ready",   in_ready_o, 1);
        check("rst_lanevld", out_lane_vld_o, 0);
        check("rst_rs",      out_rs_ent_o, 0);
        check("rst_payload", out_payload_o, 0);
        reset_i = 1'b0;
        tick();

        // 1: async reset mid-stream with three entries held
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b00, 3'd1, 64'h30 + k, 64'h130 + k);
            tick();
        end
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        check("t1_count3", count_o, 3);
        check("t1_head",   out_payload_o[63:0], 64'h30);
        #2 reset_i = 1'b1;
        #1;
        check("t1_async_count",   count_o, 0);
        check("t1_async_valid",   out_valid_o, 0);
        check("t1_async_ready",   in_ready_o, 1);
        check("t1_async_payload", out_payload_o, 0);
        tick();
        reset_i = 1'b0;
        tick();
        check("t1_after_count", count_o, 0);
        check("t1_after_valid", out_valid_o, 0);

        // 2: fill to DEPTH with dispatch stalled, then drain in order
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b00, 3'd2, 64'h10 + k, 64'h110 + k);
            tick();
        end
        check("t2_full_count", count_o, 4);
        check("t2_full_ready", in_ready_o, 0);
        drive(1'b1, 2'b00, 3'd2, 64'h99, 64'h199);
        tick();
        check("t2_holdoff_count", count_o, 4);
        check("t2_holdoff_head",  out_payload_o[63:0], 64'h10);
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_pop_valid",  out_valid_o, 1);
            check("t2_pop_lane0",  out_payload_o[63:0], 64'h10 + k);
            check("t2_pop_lane1",  out_payload_o[127:64], 64'h110 + k);
            check("t2_pop_rs",     out_rs_ent_o, 6'o22);
            tick();
        end
        check("t2_drained_valid", out_valid_o, 0);
        check("t2_drained_count", count_o, 0);

        // 3: steady stream across pointer wraps
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 2'b00, 3'd3, 64'hA0 + k, 64'd0);
`ifdef ID_DISPATCH_BYPASS_EN
            #1;
            check("t3_byp_valid",   out_valid_o, 1);
            check("t3_byp_payload", out_payload_o[63:0], 64'hA0 + k);
            check("t3_byp_count",   count_o, 0);
            tick();
`else
            tick();
            check("t3_count",   count_o, 1);
            check("t3_payload", out_payload_o[63:0], 64'hA0 + k);
`endif
        end
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        tick();
        check("t3_drained_count", count_o, 0);

        // 4: per-lane invalid masking, all-invalid bundle not stored
        out_ready_i = 1'b0;
        drive(1'b1, 2'b10, 3'd5, 64'h44, 64'h45);
        tick();
        check("t4_count",    count_o, 1);
        check("t4_lane_vld", out_lane_vld_o, 2'b01);
        check("t4_rs",       out_rs_ent_o, 6'b000_101);
        drive(1'b1, 2'b11, 3'd5, 64'h46, 64'h47);
        #1;
        check("t4_allinv_ready", in_ready_o, 1);
        tick();
        check("t4_allinv_count", count_o, 1);
        check("t4_allinv_head",  out_payload_o[63:0], 64'h44);
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        out_ready_i = 1'b1;
        tick();
        check("t4_drained_count", count_o, 0);

        // 5: kill with concurrent push and pop
        out_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 2'b00, 3'd1, 64'h60 + k, 64'd0);
            tick();
        end
        check("t5_count2", count_o, 2);
        drive(1'b1, 2'b00, 3'd1, 64'h62, 64'd0);
        out_ready_i = 1'b1;
        kill_i      = 1'b1;
        tick();
        kill_i      = 1'b0;
        out_ready_i = 1'b0;
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        check("t5_kill_count",   count_o, 0);
        check("t5_kill_valid",   out_valid_o, 0);
        check("t5_kill_ready",   in_ready_o, 1);
        check("t5_kill_payload", out_payload_o, 0);
        drive(1'b1, 2'b00, 3'd1, 64'h77, 64'd0);
        tick();
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        check("t5_post_count", count_o, 1);
        check("t5_post_head",  out_payload_o[63:0], 64'h77);
        out_ready_i = 1'b1;
        tick();
        check("t5_post_drained", count_o, 0);

        // 6: latency from empty with dispatch ready
        out_ready_i = 1'b1;
        drive(1'b1, 2'b00, 3'd4, 64'h55, 64'd0);
        #1;
`ifdef ID_DISPATCH_BYPASS_EN
        check("t6_same_valid",   out_valid_o, 1);
        check("t6_same_payload", out_payload_o[63:0], 64'h55);
        check("t6_same_count",   count_o, 0);
        tick();
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        check("t6_next_count",   count_o, 0);
        check("t6_next_valid",   out_valid_o, 0);
`else
        check("t6_same_valid",   out_valid_o, 0);
        check("t6_same_payload", out_payload_o, 0);
        tick();
        drive(1'b0, 2'b00, 3'd0, 64'd0, 64'd0);
        check("t6_next_valid",   out_valid_o, 1);
        check("t6_next_payload", out_payload_o[63:0], 64'h55);
        check("t6_next_count",   count_o, 1);
        tick();
        check("t6_drained_count", count_o, 0);
        check("t6_drained_valid", out_valid_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
